// File: rtl/register_file_ctx.sv
// register_file_ctx: parameterised register file with PC mirror register,
// optional hardwired zero register, optional write-to-read bypass and a
// shadow bank copied in/out one entry per cycle by a small save/restore engine.
module register_file_ctx #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 5,
  parameter int PC_WIDTH    = 10,
  parameter int PC_REG      = 28,
  parameter int PC_LIMIT    = 256,
  parameter bit ZERO_REG_EN = 1'b0,
  parameter bit BYPASS_EN   = 1'b1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  write_register,
  input  logic [ADDR_WIDTH-1:0] write_address,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic [ADDR_WIDTH-1:0] read_address1,
  input  logic [ADDR_WIDTH-1:0] read_address2,
  input  logic [PC_WIDTH-1:0]   program_counter,
  input  logic                  save_request,
  input  logic                  restore_request,
  output logic [DATA_WIDTH-1:0] data_a,
  output logic [DATA_WIDTH-1:0] data_b,
  output logic [DATA_WIDTH-1:0] data_c,
  output logic                  busy,
  output logic                  done,
  output logic                  write_dropped
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SAVE    = 2'd1,
    RESTORE = 2'd2
  } state_t;

  state_t                state;
  state_t                state_next;
  logic [ADDR_WIDTH-1:0] index;
  logic [ADDR_WIDTH-1:0] index_next;
  logic                  done_next;

  logic [DATA_WIDTH-1:0] rf     [DEPTH];
  logic [DATA_WIDTH-1:0] shadow [DEPTH];

  logic                  mirror_active;
  logic [DATA_WIDTH-1:0] pc_value;
  logic                  user_write;
  logic                  bypass_ok;

  // The mirror compare is unsigned; widen both sides so any PC_WIDTH works.
  assign mirror_active = 64'(program_counter) < $unsigned(64'(PC_LIMIT));
  assign pc_value      = DATA_WIDTH'(program_counter);

  assign busy       = (state != IDLE);
  assign user_write = write_register && !busy;

  // Bypass only forwards data that will actually land in the main bank on
  // the next edge: writes blocked by busy, the zero register or the PC
  // mirror must not be visible early.
  assign bypass_ok = BYPASS_EN && user_write
                     && !(ZERO_REG_EN && (write_address == '0))
                     && !(mirror_active && (write_address == ADDR_WIDTH'(PC_REG)));

  function automatic logic [DATA_WIDTH-1:0] read_port(input logic [ADDR_WIDTH-1:0] addr);
    logic [DATA_WIDTH-1:0] value;
    value = rf[addr];
    if (bypass_ok && (addr == write_address)) value = write_data;
    if (ZERO_REG_EN && (addr == '0)) value = '0;
    return value;
  endfunction

  assign data_a = read_port(write_address);
  assign data_b = read_port(read_address1);
  assign data_c = read_port(read_address2);

  // Save/restore sequencing: walk index 0..DEPTH-1, then return to IDLE with done.
  always_comb begin
    state_next = state;
    index_next = index;
    done_next  = 1'b0;
    unique case (state)
      IDLE: begin
        index_next = '0;
        if (save_request)         state_next = SAVE;
        else if (restore_request) state_next = RESTORE;
      end
      SAVE, RESTORE: begin
        if (index == '1) begin
          state_next = IDLE;
          index_next = '0;
          done_next  = 1'b1;
        end else begin
          index_next = index + 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        index_next = '0;
      end
    endcase
  end

  // Control registers: FSM state, copy index and the one-cycle status pulses.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      index         <= '0;
      done          <= 1'b0;
      write_dropped <= 1'b0;
    end else begin
      state         <= state_next;
      index         <= index_next;
      done          <= done_next;
      write_dropped <= write_register && busy;
    end
  end

  // Main bank update: PC mirror beats restore copy, which beats user write.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) rf[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (!(ZERO_REG_EN && (i == 0))) begin
          if (mirror_active && (i == PC_REG))
            rf[i] <= pc_value;
          else if ((state == RESTORE) && (index == ADDR_WIDTH'(i)))
            rf[i] <= shadow[i];
          else if (user_write && (write_address == ADDR_WIDTH'(i)))
            rf[i] <= write_data;
        end
      end
    end
  end

  // Shadow bank: one entry captured from the live main bank per SAVE cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) shadow[i] <= '0;
    end else if (state == SAVE) begin
      shadow[index] <= rf[index];
    end
  end

endmodule

// File: tb/tb_register_file_ctx.sv
// tb_register_file_ctx: scoreboard bench for register_file_ctx. A default
// instance (bypass on, no zero register) and a second instance with the zero
// register enabled and bypass disabled share the same stimulus.
module tb_register_file_ctx;

  localparam int DEPTH = 32;

  localparam int S_A    = 0;
  localparam int S_B    = 1;
  localparam int S_C    = 2;
  localparam int S_BUSY = 3;
  localparam int S_DONE = 4;
  localparam int S_WD   = 5;
  localparam int S_ZB   = 6;

  logic        clock;
  logic        reset_n;
  logic        write_register;
  logic [4:0]  write_address;
  logic [31:0] write_data;
  logic [4:0]  read_address1;
  logic [4:0]  read_address2;
  logic [9:0]  program_counter;
  logic        save_request;
  logic        restore_request;

  logic [31:0] data_a, data_b, data_c;
  logic        busy, done, write_dropped;
  logic [31:0] z_data_a, z_data_b, z_data_c;
  logic        z_busy, z_done, z_write_dropped;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  exp_t sbq[$];

  register_file_ctx dut (
    .clock(clock), .reset_n(reset_n), .write_register(write_register),
    .write_address(write_address), .write_data(write_data),
    .read_address1(read_address1), .read_address2(read_address2),
    .program_counter(program_counter), .save_request(save_request),
    .restore_request(restore_request), .data_a(data_a), .data_b(data_b),
    .data_c(data_c), .busy(busy), .done(done), .write_dropped(write_dropped)
  );

  register_file_ctx #(.ZERO_REG_EN(1'b1), .BYPASS_EN(1'b0)) dut_z (
    .clock(clock), .reset_n(reset_n), .write_register(write_register),
    .write_address(write_address), .write_data(write_data),
    .read_address1(read_address1), .read_address2(read_address2),
    .program_counter(program_counter), .save_request(save_request),
    .restore_request(restore_request), .data_a(z_data_a), .data_b(z_data_b),
    .data_c(z_data_c), .busy(z_busy), .done(z_done), .write_dropped(z_write_dropped)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] observe(input int sel);
    case (sel)
      S_A:     return data_a;
      S_B:     return data_b;
      S_C:     return data_c;
      S_BUSY:  return 32'(busy);
      S_DONE:  return 32'(done);
      S_WD:    return 32'(write_dropped);
      S_ZB:    return z_data_b;
      default: return 32'hxxxxxxxx;
    endcase
  endfunction

  task automatic push(input string tag, input int sel, input logic [31:0] exp);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = exp;
    sbq.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      check_val(e.tag, observe(e.sel), e.exp);
    end
  endtask

  // Drive point: just after the rising edge.
  task automatic next();
    @(posedge clock);
    #1;
  endtask

  // Sample point: near the falling edge, well away from the active edge.
  task automatic check_now();
    #4;
    drain();
  endtask

  task automatic wr(input logic [4:0] addr, input logic [31:0] value);
    next();
    write_register = 1'b1;
    write_address  = addr;
    write_data     = value;
    next();
    write_register = 1'b0;
  endtask

  // Runs one save/restore operation; optionally injects a user write while
  // busy at cycle drop_at, and a restore request mid-operation that must be ignored.
  task automatic run_op(input bit s, input bit r, input int drop_at);
    next();
    save_request    = s;
    restore_request = r;
    push("op_idle_busy", S_BUSY, 32'd0);
    check_now();
    next();
    save_request    = 1'b0;
    restore_request = 1'b0;
    for (int n = 1; n <= DEPTH; n++) begin
      if (n == 5)  restore_request = 1'b1;
      if (n == 6)  restore_request = 1'b0;
      if (drop_at != 0 && n == drop_at) begin
        write_register = 1'b1;
        write_address  = 5'd3;
        write_data     = 32'h77;
        read_address1  = 5'd3;
        push("busy_no_bypass_b", S_B, 32'd0);
        push("busy_no_bypass_a", S_A, 32'd0);
      end
      if (drop_at != 0 && n == drop_at + 1) begin
        write_register = 1'b0;
        push("write_dropped", S_WD, 32'd1);
        push("dropped_no_change", S_B, 32'd0);
      end
      if (drop_at != 0 && n == drop_at + 2) push("write_dropped_clr", S_WD, 32'd0);
      push("op_busy", S_BUSY, 32'd1);
      push("op_done_low", S_DONE, 32'd0);
      check_now();
      next();
    end
    push("op_busy_end", S_BUSY, 32'd0);
    push("op_done", S_DONE, 32'd1);
    check_now();
    next();
    push("op_done_clr", S_DONE, 32'd0);
    push("op_no_requeue", S_BUSY, 32'd0);
    check_now();
  endtask

  initial begin
    reset_n         = 1'b0;
    write_register  = 1'b0;
    write_address   = '0;
    write_data      = '0;
    read_address1   = '0;
    read_address2   = '0;
    program_counter = 10'd300;
    save_request    = 1'b0;
    restore_request = 1'b0;

    // Reset state: every address reads zero, status low.
    #2;
    for (int i = 0; i < DEPTH; i++) begin
      write_address = 5'(i);
      read_address1 = 5'(i);
      read_address2 = 5'(i);
      #1;
      push("rst_a", S_A, 32'd0);
      push("rst_b", S_B, 32'd0);
      push("rst_c", S_C, 32'd0);
      drain();
    end
    push("rst_busy", S_BUSY, 32'd0);
    push("rst_done", S_DONE, 32'd0);
    push("rst_wd", S_WD, 32'd0);
    drain();

    next();
    reset_n = 1'b1;

    // Bypass: same-cycle forwarding on the default instance only.
    next();
    write_register = 1'b1;
    write_address  = 5'd5;
    write_data     = 32'hDEADBEEF;
    read_address1  = 5'd5;
    push("bypass_b", S_B, 32'hDEADBEEF);
    push("bypass_a", S_A, 32'hDEADBEEF);
    push("nobypass_b", S_ZB, 32'd0);
    check_now();
    next();
    write_register = 1'b0;
    push("written_b", S_B, 32'hDEADBEEF);
    push("nobypass_written_b", S_ZB, 32'hDEADBEEF);
    check_now();

    // Zero register: blocked on the zero instance, ordinary on the default one.
    next();
    write_register = 1'b1;
    write_address  = 5'd0;
    write_data     = 32'hFFFFFFFF;
    read_address1  = 5'd0;
    push("zero_now", S_ZB, 32'd0);
    push("r0_bypass", S_B, 32'hFFFFFFFF);
    check_now();
    next();
    write_register = 1'b0;
    push("zero_after", S_ZB, 32'd0);
    push("r0_written", S_B, 32'hFFFFFFFF);
    check_now();

    // PC mirror priority over user write to PC_REG.
    read_address2 = 5'd28;
    next();
    program_counter = 10'h0A5;
    write_register  = 1'b1;
    write_address   = 5'd28;
    write_data      = 32'h1234;
    push("pc_no_bypass_c", S_C, 32'd0);
    push("pc_no_bypass_a", S_A, 32'd0);
    check_now();
    next();
    write_register = 1'b0;
    push("pc_mirror", S_C, 32'h000000A5);
    check_now();
    next();
    program_counter = 10'd300;
    write_register  = 1'b1;
    write_data      = 32'h1234;
    push("pc_off_bypass", S_C, 32'h1234);
    check_now();
    next();
    write_register = 1'b0;
    push("pc_off_write", S_C, 32'h1234);
    check_now();

    // Save/restore round trip.
    program_counter = 10'h040;
    wr(5'd1, 32'h11);
    wr(5'd2, 32'h22);
    read_address1 = 5'd1;
    read_address2 = 5'd2;
    push("pre_r1", S_B, 32'h11);
    push("pre_r2", S_C, 32'h22);
    check_now();
    run_op(1'b1, 1'b0, 3);
    wr(5'd1, 32'h99);
    read_address1 = 5'd1;
    push("overwrite_r1", S_B, 32'h99);
    check_now();
    next();
    program_counter = 10'h041;
    run_op(1'b0, 1'b1, 0);
    read_address1 = 5'd1;
    read_address2 = 5'd2;
    #1;
    push("restored_r1", S_B, 32'h11);
    push("restored_r2", S_C, 32'h22);
    drain();
    read_address2 = 5'd28;
    #1;
    push("restored_pc_live", S_C, 32'h41);
    drain();

    // Simultaneous requests: save wins.
    wr(5'd1, 32'h55);
    run_op(1'b1, 1'b1, 0);
    read_address1 = 5'd1;
    #1;
    push("both_req_r1", S_B, 32'h55);
    drain();
    wr(5'd1, 32'h66);
    run_op(1'b0, 1'b1, 0);
    read_address1 = 5'd1;
    #1;
    push("both_req_saved", S_B, 32'h55);
    drain();

    // Reset during RESTORE: immediate clear, no done.
    next();
    restore_request = 1'b1;
    next();
    restore_request = 1'b0;
    repeat (9) next();
    push("mid_busy", S_BUSY, 32'd1);
    drain();
    reset_n = 1'b0;
    read_address1 = 5'd1;
    read_address2 = 5'd28;
    write_address = 5'd5;
    #1;
    push("abort_busy", S_BUSY, 32'd0);
    push("abort_r1", S_B, 32'd0);
    push("abort_r28", S_C, 32'd0);
    push("abort_r5", S_A, 32'd0);
    drain();
    next();
    reset_n = 1'b1;
    for (int n = 0; n < DEPTH + 3; n++) begin
      push("abort_no_done", S_DONE, 32'd0);
      push("abort_idle", S_BUSY, 32'd0);
      check_now();
      next();
    end

    // Shadow bank was cleared by reset too.
    wr(5'd1, 32'h12);
    read_address1 = 5'd1;
    push("post_rst_r1", S_B, 32'h12);
    check_now();
    run_op(1'b0, 1'b1, 0);
    read_address1 = 5'd1;
    #1;
    push("shadow_cleared", S_B, 32'd0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/register_file_ctx.md
Name: register_file_ctx

Overview:
- Parametrised successor to the processor's 32x32 register file, generalised in data width, depth and PC-mirror register.
- Adds async active-low reset clear, optional hardwired zero register, optional write-to-read bypass, and a shadow bank.
- The shadow bank has a multi-cycle save/restore engine for interrupt/context switching.
- Sits in the datapath between decode (addresses) and ALU/memory (operands), as before.

Parameters:
DATA_WIDTH, 32, register width in bits
ADDR_WIDTH, 5, address width; depth = 2**ADDR_WIDTH
PC_WIDTH, 10, program_counter width
PC_REG, 28, index of register mirroring program_counter
PC_LIMIT, 256, mirror updates only while program_counter < PC_LIMIT
ZERO_REG_EN, 0, 1 = register 0 reads 0 and ignores all writes
BYPASS_EN, 1, 1 = reads of the address being written return write_data in the same cycle

Ports:
clock  in  1  rising-edge clock
reset_n  in  1  asynchronous reset, active low
write_register  in  1  write enable
write_address  in  ADDR_WIDTH  write index; also the data_a read index
write_data  in  DATA_WIDTH  write value
read_address1  in  ADDR_WIDTH  data_b read index
read_address2  in  ADDR_WIDTH  data_c read index
program_counter  in  PC_WIDTH  current PC, mirrored into PC_REG
save_request  in  1  start copy of main bank to shadow bank
restore_request  in  1  start copy of shadow bank to main bank
data_a  out  DATA_WIDTH  RF[write_address]
data_b  out  DATA_WIDTH  RF[read_address1]
data_c  out  DATA_WIDTH  RF[read_address2]
busy  out  1  save/restore in progress
done  out  1  one-cycle pulse on completion
write_dropped  out  1  one-cycle pulse: write_register=1 was ignored because busy

Behaviour:
- Reset (reset_n=0, async): all main and shadow entries = 0; FSM = IDLE; index = 0; busy, done and write_dropped = 0.
- Reads: combinational, zero latency.
  - With BYPASS_EN=1, write_register=1 and a matching address: the read returns write_data. Bypass is suppressed when busy, when the write targets reg 0 with ZERO_REG_EN=1, and when the write targets PC_REG with the mirror active.
  - With ZERO_REG_EN=1: any read of address 0 returns 0.
- Main-bank update each rising edge, priority highest first:
  1. PC mirror: if program_counter < PC_LIMIT, RF[PC_REG] <= zero-extended program_counter. Overrides user writes and restore writes to PC_REG.
  2. Restore copy (state RESTORE): RF[index] <= SHADOW[index].
  3. User write: if write_register=1 and not busy, RF[write_address] <= write_data.
  - ZERO_REG_EN=1 blocks every write path to index 0.
- PC mirror width rule: PC_WIDTH must be <= DATA_WIDTH, upper bits zero; PC_LIMIT compare is unsigned.
- FSM states: IDLE, SAVE, RESTORE.
  - IDLE -> SAVE on save_request=1; save wins if both requests are high.
  - IDLE -> RESTORE on restore_request=1 with save_request=0.
  - Entering SAVE/RESTORE: index = 0, busy = 1 from the next cycle.
  - SAVE: SHADOW[index] <= RF[index], one entry per cycle, index++.
  - RESTORE: as per priority list above, index++.
  - At index = depth-1 the copy completes that cycle; the next cycle gives state = IDLE, busy = 0, done = 1 for exactly one cycle, index = 0.
  - Operation latency: depth cycles of busy, done in cycle depth+1 after the request edge.
  - Requests while busy are ignored, not queued.
- SAVE samples RF[index] at its copy cycle, so a PC_REG value saved reflects the PC at that cycle.
- User writes while busy: dropped; write_dropped = 1 the following cycle; no main-bank change.
- Reset mid-operation: immediate abort; both banks cleared; no done pulse.

Test Plan:
- Reset then reads: reset_n=0 -> data_a/b/c = 0 for all addresses; busy = done = 0.
- Write/read with bypass: write 0xDEADBEEF to r5 with read_address1=5 -> data_b = 0xDEADBEEF in the same cycle; BYPASS_EN=0 -> old value (0) until the next edge.
- PC mirror priority: program_counter=0x0A5 with user write 0x1234 to r28 -> r28 = 0x000000A5; with program_counter=300 -> r28 = 0x1234.
- ZERO_REG_EN=1: write 0xFFFFFFFF to r0 -> data_b at address 0 = 0 immediately and after the edge.
- Save/restore round trip (depth 32): load r1=0x11 and r2=0x22; save (busy 32 cycles, done pulse cycle 33); overwrite r1=0x99; restore -> r1 = 0x11, r2 = 0x22, r28 = live PC.
- Busy conflicts: user write during SAVE -> dropped, write_dropped pulse; save+restore together -> SAVE chosen; reset_n low at cycle 10 of RESTORE -> all zero, no done.
